// File: rtl/dma_pkg.sv
// -----------------------------------------------------------------------------
// dma_pkg
// Shared types and sizes for the DMA loader slice.
//   loader_state_t : controller states (IDLE, LOAD, RUN, DONE)
//   load_tgt_t     : which memory a load event writes (none / weight / input / instr)
//   ADDR_W, DATA_W : word address and data byte widths
//   DEPTH          : number of addressable words, also the width of the valid masks
// -----------------------------------------------------------------------------
package dma_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } loader_state_t;

  typedef enum logic [1:0] {
    TGT_NONE = 2'd0,
    TGT_W    = 2'd1,
    TGT_INP  = 2'd2,
    TGT_INS  = 2'd3
  } load_tgt_t;

endpackage

// File: rtl/dma_edge_detect.sv
// -----------------------------------------------------------------------------
// dma_edge_detect
// Turns level-held decoder commands into single-cycle events.
// A fetch line produces an event when it rises, or when it stays high while
// the address moves, so a host can stream consecutive words by holding the
// fetch line and stepping the address.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   fetch_w_i/inp_i/ins_i      decoded load commands
//   start_i                    decoded run command
//   addr_i                     target word address
//   load_evt_o                 a load event occurs this cycle
//   load_tgt_o                 memory to write (weight > input > instruction)
//   start_evt_o                rising edge of start_i
// -----------------------------------------------------------------------------
module dma_edge_detect
  import dma_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_w_i,
  input  logic              fetch_inp_i,
  input  logic              fetch_ins_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              load_evt_o,
  output load_tgt_t         load_tgt_o,
  output logic              start_evt_o
);

  logic [2:0]        fetch_now;
  logic [2:0]        fetch_q;
  logic [2:0]        fetch_evt;
  logic              start_q;
  logic [ADDR_W-1:0] addr_q;
  logic              addr_chg;

  // bit 0 = weight, bit 1 = input, bit 2 = instruction
  assign fetch_now = {fetch_ins_i, fetch_inp_i, fetch_w_i};
  assign addr_chg  = (addr_i != addr_q);

  for (genvar gi = 0; gi < 3; gi++) begin : g_evt
    assign fetch_evt[gi] = fetch_now[gi] & (~fetch_q[gi] | addr_chg);
  end

  // Only one write may be issued; the highest-priority qualifying fetch wins.
  always_comb begin
    load_tgt_o = TGT_NONE;
    if (fetch_evt[0])      load_tgt_o = TGT_W;
    else if (fetch_evt[1]) load_tgt_o = TGT_INP;
    else if (fetch_evt[2]) load_tgt_o = TGT_INS;
  end

  assign load_evt_o  = |fetch_evt;
  assign start_evt_o = start_i & ~start_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_q <= '0;
      start_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      fetch_q <= fetch_now;
      start_q <= start_i;
      addr_q  <= addr_i;
    end
  end

endmodule

// File: rtl/dma_loader.sv
// -----------------------------------------------------------------------------
// dma_loader
// Loads weight / input / instruction words from the host into the core's
// memories and launches the core once every required weight and input word
// has been written. Valid masks survive a run, so weights can be reused.
// Optional feature: define DMA_LOADER_WATCHDOG_EN to add an 8-bit RUN-state
// watchdog that aborts to IDLE (setting err) after TIMEOUT cycles without
// core_done. Without the macro, RUN waits for core_done indefinitely.
// Parameters:
//   W_WORDS    weight words (0..W_WORDS-1) needed before a start is accepted
//   INP_WORDS  input words needed before a start is accepted
//   TIMEOUT    watchdog limit in cycles (1..255)
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   fetch_w, fetch_inp, fetch_ins    decoded load commands
//   start                            decoded run command
//   dma_address, data_in             target word address and load data
//   core_done                        completion pulse from the core
//   w_we, inp_we, ins_we             single-cycle memory write strobes
//   mem_addr, mem_wdata              registered write address and data
//   core_start                       single-cycle run pulse to the core
//   busy, done, err                  running / run complete / sticky error
// -----------------------------------------------------------------------------
module dma_loader
  import dma_pkg::*;
#(
  parameter int W_WORDS   = 4,
  parameter int INP_WORDS = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_w,
  input  logic              fetch_inp,
  input  logic              fetch_ins,
  input  logic              start,
  input  logic [ADDR_W-1:0] dma_address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              core_done,
  output logic              w_we,
  output logic              inp_we,
  output logic              ins_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_start,
  output logic              busy,
  output logic              done,
  output logic              err
);

  if (W_WORDS < 1 || W_WORDS > DEPTH || INP_WORDS < 1 || INP_WORDS > DEPTH ||
      TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
    $error("dma_loader: parameter out of range");
  end

  // Masks of the words that must be valid before a run may start.
  localparam logic [DEPTH-1:0] W_NEED   = DEPTH'((64'd1 << W_WORDS) - 64'd1);
  localparam logic [DEPTH-1:0] INP_NEED = DEPTH'((64'd1 << INP_WORDS) - 64'd1);
  localparam logic [ADDR_W:0]  W_LIM    = (ADDR_W + 1)'(W_WORDS);
  localparam logic [ADDR_W:0]  INP_LIM  = (ADDR_W + 1)'(INP_WORDS);

  loader_state_t     state_q, state_d;
  logic [DEPTH-1:0]  w_valid_q, w_valid_d;
  logic [DEPTH-1:0]  inp_valid_q, inp_valid_d;
  logic              err_q, err_d;
  logic              w_we_q, w_we_d;
  logic              inp_we_q, inp_we_d;
  logic              ins_we_q, ins_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              core_start_q, core_start_d;

`ifdef DMA_LOADER_WATCHDOG_EN
  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);
  logic [7:0] wd_q, wd_d;
`endif

  logic       load_evt;
  load_tgt_t  load_tgt;
  logic       start_evt;
  logic       ready;
  logic       range_err;

  dma_edge_detect u_edge (
    .clk         (clk),
    .reset       (reset),
    .fetch_w_i   (fetch_w),
    .fetch_inp_i (fetch_inp),
    .fetch_ins_i (fetch_ins),
    .start_i     (start),
    .addr_i      (dma_address),
    .load_evt_o  (load_evt),
    .load_tgt_o  (load_tgt),
    .start_evt_o (start_evt)
  );

  assign ready = ((w_valid_q & W_NEED) == W_NEED) &&
                 ((inp_valid_q & INP_NEED) == INP_NEED);

  always_comb begin
    state_d      = state_q;
    w_valid_d    = w_valid_q;
    inp_valid_d  = inp_valid_q;
    err_d        = err_q;
    w_we_d       = 1'b0;
    inp_we_d     = 1'b0;
    ins_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    core_start_d = 1'b0;
    range_err    = 1'b0;
`ifdef DMA_LOADER_WATCHDOG_EN
    wd_d         = wd_q;
`endif

    case (state_q)
      RUN: begin
        // The core owns the memories: loads and starts are refused and flagged.
        if (load_evt || start_evt) err_d = 1'b1;
        if (core_done) begin
          state_d = DONE;
        end
`ifdef DMA_LOADER_WATCHDOG_EN
        else if (wd_q == WD_LIMIT) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 8'd1;
        end
`endif
      end

      default: begin
        if (load_evt) begin
          state_d     = LOAD;
          mem_addr_d  = dma_address;
          mem_wdata_d = data_in;
          case (load_tgt)
            TGT_W: begin
              w_we_d                 = 1'b1;
              w_valid_d[dma_address] = 1'b1;
              range_err              = ({1'b0, dma_address} >= W_LIM);
            end
            TGT_INP: begin
              inp_we_d                 = 1'b1;
              inp_valid_d[dma_address] = 1'b1;
              range_err                = ({1'b0, dma_address} >= INP_LIM);
            end
            TGT_INS: ins_we_d = 1'b1;
            default: ;
          endcase
        end
        // A start overrides the LOAD move; an out-of-range write in the same
        // cycle still leaves err set.
        if (start_evt) begin
          if (ready) begin
            core_start_d = 1'b1;
            err_d        = 1'b0;
            state_d      = RUN;
`ifdef DMA_LOADER_WATCHDOG_EN
            wd_d         = 8'd0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
        if (range_err) err_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      w_valid_q    <= '0;
      inp_valid_q  <= '0;
      err_q        <= 1'b0;
      w_we_q       <= 1'b0;
      inp_we_q     <= 1'b0;
      ins_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_start_q <= 1'b0;
`ifdef DMA_LOADER_WATCHDOG_EN
      wd_q         <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      w_valid_q    <= w_valid_d;
      inp_valid_q  <= inp_valid_d;
      err_q        <= err_d;
      w_we_q       <= w_we_d;
      inp_we_q     <= inp_we_d;
      ins_we_q     <= ins_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_start_q <= core_start_d;
`ifdef DMA_LOADER_WATCHDOG_EN
      wd_q         <= wd_d;
`endif
    end
  end

  assign w_we       = w_we_q;
  assign inp_we     = inp_we_q;
  assign ins_we     = ins_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_start = core_start_q;
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign err        = err_q;

endmodule
